// File: rtl/char_pool_if.sv
// rtl/char_pool_if.sv - bus bundle between the character pool and its neighbours
// Purpose: groups the generator, keyboard, frame, renderer read port and
//          score outputs of char_pool into one interface.
// Ports (signals):
//   spawn, gen_ch[7:0], gen_speed[2:0], gen_x[8:0], gen_y[9:0] : new character from the generator
//   frame_tick                                                 : one pulse per video frame
//   key_valid, key_ch[7:0]                                     : typed key
//   rd_idx, rd_active, rd_ch, rd_x, rd_y                       : renderer read port
//   hit, miss, drop                                            : one-cycle event pulses
//   hit_count[15:0], miss_count[7:0], active_count             : score / population counters
// Modports: master drives the inputs of the pool, slave is the pool itself.
interface char_pool_if #(
  parameter int SLOTS = 8
);
  localparam int IDX_W = $clog2(SLOTS);

  logic             spawn;
  logic [7:0]       gen_ch;
  logic [2:0]       gen_speed;
  logic [8:0]       gen_x;
  logic [9:0]       gen_y;
  logic             frame_tick;
  logic             key_valid;
  logic [7:0]       key_ch;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_active;
  logic [7:0]       rd_ch;
  logic [8:0]       rd_x;
  logic [9:0]       rd_y;
  logic             hit;
  logic             miss;
  logic             drop;
  logic [15:0]      hit_count;
  logic [7:0]       miss_count;
  logic [IDX_W:0]   active_count;

  modport master (
    output spawn, gen_ch, gen_speed, gen_x, gen_y,
    output frame_tick, key_valid, key_ch, rd_idx,
    input  rd_active, rd_ch, rd_x, rd_y,
    input  hit, miss, drop, hit_count, miss_count, active_count
  );

  modport slave (
    input  spawn, gen_ch, gen_speed, gen_x, gen_y,
    input  frame_tick, key_valid, key_ch, rd_idx,
    output rd_active, rd_ch, rd_x, rd_y,
    output hit, miss, drop, hit_count, miss_count, active_count
  );
endinterface

// File: rtl/char_pool.sv
// rtl/char_pool.sv - fixed-size table of falling characters for the typing game
// Purpose: holds up to SLOTS falling characters; loads new ones on spawn,
//          advances them on frame_tick, retires them on a matching key (hit)
//          or when they reach X_MAX (miss).
// Parameters: SLOTS (2..16), X_MAX (bottom row threshold, 9 bits).
// Ports: clk, rst (synchronous, active-high), bus (char_pool_if.slave) carrying
//        spawn/gen_*, frame_tick, key_valid/key_ch, the rd_* read port,
//        hit/miss/drop pulses and hit_count/miss_count/active_count.
// Build option: define CHAR_POOL_CASE_FOLD_EN to let lowercase keys match
//               uppercase characters.
module char_pool #(
  parameter int         SLOTS = 8,
  parameter logic [8:0] X_MAX = 9'd460
) (
  input  logic        clk,
  input  logic        rst,
  char_pool_if.slave  bus
);
  localparam int IDX_W = $clog2(SLOTS);
  localparam int CNT_W = IDX_W + 1;

  // Slot storage
  logic [SLOTS-1:0] active;
  logic [7:0]       ch    [SLOTS];
  logic [2:0]       speed [SLOTS];
  logic [8:0]       x     [SLOTS];
  logic [9:0]       y     [SLOTS];

  // Output registers
  logic             hit_q;
  logic             miss_q;
  logic             drop_q;
  logic [15:0]      hit_count_q;
  logic [7:0]       miss_count_q;
  logic [CNT_W-1:0] active_count_q;

  // Key code used for matching
  logic [7:0] key_cmp;
`ifdef CHAR_POOL_CASE_FOLD_EN
  always_comb begin
    key_cmp = bus.key_ch;
    if (bus.key_ch >= 8'd97 && bus.key_ch <= 8'd122) key_cmp = bus.key_ch - 8'd32;
  end
`else
  always_comb begin
    key_cmp = bus.key_ch;
  end
`endif

  // Key winner: deepest matching slot; strict '>' keeps the lowest index on ties.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [8:0]       win_x;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_x     = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (active[i] && ch[i] == key_cmp && (!win_found || x[i] > win_x)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_x     = x[i];
      end
    end
  end

  logic key_hit;
  assign key_hit = bus.key_valid && win_found;

  // Per-slot retire / advance decisions, all from registered state.
  logic [SLOTS-1:0] hit_sel;
  logic [SLOTS-1:0] miss_sel;
  logic [8:0]       adv_x [SLOTS];
  logic [9:0]       sum_x [SLOTS];
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      sum_x[i]    = {1'b0, x[i]} + {7'd0, speed[i]};
      adv_x[i]    = sum_x[i][8:0];
      hit_sel[i]  = key_hit && (win_idx == IDX_W'(i));
      // A same-cycle key winner is a hit, never a miss.
      miss_sel[i] = bus.frame_tick && active[i] && !hit_sel[i] &&
                    (sum_x[i] >= {1'b0, X_MAX});
    end
  end

  // Spawn target: lowest slot free in the registered state, so slots freed
  // this cycle only become eligible next cycle.
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!active[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Population counts
  logic [CNT_W-1:0] miss_n;
  logic [CNT_W-1:0] pop;
  always_comb begin
    miss_n = '0;
    pop    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      miss_n = miss_n + CNT_W'(miss_sel[i]);
      pop    = pop + CNT_W'(active[i]);
    end
  end

  logic [8:0] miss_sum;
  logic [7:0] miss_sat;
  always_comb begin
    miss_sum = {1'b0, miss_count_q} + 9'(miss_n);
    miss_sat = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active         <= '0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      drop_q         <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      active_count_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        ch[i]    <= '0;
        speed[i] <= '0;
        x[i]     <= '0;
        y[i]     <= '0;
      end
    end else begin
      hit_q          <= key_hit;
      miss_q         <= |miss_sel;
      drop_q         <= bus.spawn && !free_found;
      active_count_q <= pop;
      miss_count_q   <= miss_sat;
      if (key_hit && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      for (int i = 0; i < SLOTS; i++) begin
        if (hit_sel[i] || miss_sel[i]) begin
          active[i] <= 1'b0;
        end else if (bus.frame_tick && active[i]) begin
          x[i] <= adv_x[i];
        end
        // The target is inactive, so it never collides with the retire/advance above.
        if (bus.spawn && free_found && free_idx == IDX_W'(i)) begin
          active[i] <= 1'b1;
          ch[i]     <= bus.gen_ch;
          speed[i]  <= bus.gen_speed;
          x[i]      <= bus.gen_x;
          y[i]      <= bus.gen_y;
        end
      end
    end
  end

  // Read port: combinational, inactive slots read as zero.
  logic rd_ok;
  always_comb begin
    rd_ok         = (int'(bus.rd_idx) < SLOTS) && active[bus.rd_idx];
    bus.rd_active = rd_ok;
    bus.rd_ch     = rd_ok ? ch[bus.rd_idx] : 8'd0;
    bus.rd_x      = rd_ok ? x[bus.rd_idx]  : 9'd0;
    bus.rd_y      = rd_ok ? y[bus.rd_idx]  : 10'd0;
  end

  assign bus.hit          = hit_q;
  assign bus.miss         = miss_q;
  assign bus.drop         = drop_q;
  assign bus.hit_count    = hit_count_q;
  assign bus.miss_count   = miss_count_q;
  assign bus.active_count = active_count_q;
endmodule

// File: doc/char_pool.md
# char_pool

Fixed-size table of falling characters for the typing game. Accepts each new character from the character generator (code, speed, column) and holds it in a free slot. Advances every slot by its speed on each frame tick, and retires a slot when the player types its character or when it reaches the bottom. Sits between the generator and the VGA renderer/score logic; the renderer scans slots through a read port.

## Interface

- `SLOTS`, 8: number of character slots (2..16).
- `X_MAX`, 9'd460: bottom row threshold; a character at or beyond it is missed.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `spawn` in 1: one-cycle pulse; latch the generator outputs into a free slot.
- `gen_ch` in 8: ASCII code of the new character ('A'..'Z').
- `gen_speed` in 3: pixels per frame tick (1..3; 0 is legal and means stationary).
- `gen_x` in 9: starting vertical position (generator drives 0).
- `gen_y` in 10: horizontal column.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `key_valid` in 1: one-cycle pulse, a key was typed.
- `key_ch` in 8: ASCII code of the typed key.
- `rd_idx` in $clog2(SLOTS): slot index for the renderer.
- `rd_active` out 1: the addressed slot is occupied.
- `rd_ch` out 8, `rd_x` out 9, `rd_y` out 10: contents of the addressed slot.
- `hit` out 1: one-cycle pulse, a typed key retired a slot.
- `miss` out 1: one-cycle pulse, one or more slots reached `X_MAX`.
- `drop` out 1: one-cycle pulse, a spawn was discarded because the pool was full.
- `hit_count` out 16: total hits, saturating at 16'hFFFF.
- `miss_count` out 8: total missed characters, saturating at 8'hFF.
- `active_count` out $clog2(SLOTS)+1: number of occupied slots.

## Operation

- Per slot registers: `active`, `ch[7:0]`, `speed[2:0]`, `x[8:0]`, `y[9:0]`.
- All three events below are evaluated against the registered state at the start of the same cycle. Results commit at the clock edge.
- **Key match** (`key_valid`):
  - Candidates are active slots with `ch == key_ch`.
  - Winner is the candidate with the largest `x`; ties go to the lowest index.
  - The winner is cleared, `hit` pulses, and `hit_count` increments.
  - No candidate: no effect and no pulse.
- **Frame tick** (`frame_tick`):
  - Every active slot that is not the key winner updates `x <= x + speed`, computed 10 bits wide.
  - If the sum is ≥ `X_MAX`, the slot is cleared instead.
  - Each cleared slot adds 1 to `miss_count` (saturating). `miss` pulses if at least one slot was cleared.
  - A key winner on the same cycle counts as a hit, never a miss.
- **Spawn** (`spawn`):
  - Target is the lowest-index slot that is inactive in the registered state.
  - A slot freed by hit or miss in this cycle is not eligible until the next cycle.
  - The target is loaded with the `gen_*` values and `active=1`. The new slot is not advanced by a same-cycle tick.
  - No free slot: nothing is loaded, `drop` pulses, and counters are unchanged.
- `active_count` is the registered population count of `active`, updated every cycle.
- Read port is combinational from the slot registers. An inactive slot reads `rd_ch=0`, `rd_x=0`, `rd_y=0`.

## Timing

- Reset values: all `active=0`; all slot fields 0; `hit=miss=drop=0`; `hit_count=0`, `miss_count=0`, `active_count=0`.
- `rst` overrides every event in the same cycle; pending `spawn`, `key_valid` and `frame_tick` inputs are discarded.
- Latency: an event on cycle N is visible on slot registers, pulses and counters after edge N. Pulses are high during cycle N+1 only.
- `active_count` reflects edge N state one cycle later, at edge N+1.
- Read port reflects slot registers with zero added latency.
- No handshake/backpressure: the generator and keyboard never stall; overflow is reported only via `drop`.

## Configuration

- `CHAR_POOL_CASE_FOLD_EN` defined: a `key_ch` in 8'd97..8'd122 ('a'..'z') is reduced by 32 before comparison, so 'a' retires 'A'. All other codes are compared unchanged.
- Not defined: exact 8-bit comparison; 'a' never matches 'A'.

## Test plan

- **Reset/spawn fill:** reset, then 9 spawn pulses with `gen_ch`=65..73, `gen_speed`=1, `gen_y`=k*9 → slots 0..7 loaded in order; `active_count`=8; 9th spawn gives `drop`=1 and no slot changed.
- **Advance and miss:** one slot with x=0, speed=3, `X_MAX`=460; 153 ticks → x=459, still active; 154th tick → slot cleared, `miss`=1, `miss_count`=1.
- **Key priority:** two 'B' slots, slot 1 x=40 and slot 4 x=100; `key_ch`=66 → slot 4 cleared, `hit`=1, `hit_count`=1; repeat → slot 1 cleared; third press → no pulse.
- **Simultaneous events:** full pool with slot 2 at x=458, speed=2, ch='C'; same cycle `frame_tick`, `key_ch`=67 and `spawn` → slot 2 hit (no miss), spawn dropped; next-cycle spawn lands in slot 2.
- **Case fold:** slot with 'Q'; `key_ch`=113 → hit only when `CHAR_POOL_CASE_FOLD_EN` is defined; without it no hit, then `key_ch`=81 hits.
- **Reset mid-operation:** 5 active slots, `hit_count`=3; assert `rst` together with `key_valid` and `frame_tick` → all outputs at reset values the next cycle, with no pulses.
